// File: rtl/led_breathe.sv
// PWM LED driver: off / on / blink / breathe, with duty and mode changes
// applied only at PWM period boundaries so the output never glitches.
module led_breathe #(
  parameter int PRESC    = 390,
  parameter int PWM_W    = 8,
  parameter int STEP_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic             LED,
  output logic             period_tick,
  output logic [PWM_W-1:0] duty
);

  localparam int PCW  = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int SDW  = $clog2(STEP_DIV);
  // per_cnt serves both the blink half-period and the breathe step divider
  localparam int PERW = (PWM_W > SDW) ? PWM_W : SDW;

  localparam logic [PWM_W-1:0] DMAX  = '1;
  localparam logic [PWM_W-1:0] DONE  = PWM_W'(1);
  localparam logic [PCW-1:0]   PLAST = PCW'(PRESC - 1);
  localparam logic [PERW-1:0]  BLAST = PERW'(DMAX);
  localparam logic [PERW-1:0]  SLAST = PERW'(STEP_DIV - 1);

  typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BREATHE} mode_t;
  typedef enum logic {UP, DOWN} state_t;

  logic [PCW-1:0]   presc_cnt;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PERW-1:0]  per_cnt;
  mode_t            mode_q;
  state_t           state;
  logic             stb, boundary;

  assign stb      = en && (presc_cnt == PLAST);
  assign boundary = stb && (pwm_cnt == DMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt   <= '0;
      pwm_cnt     <= '0;
      per_cnt     <= '0;
      duty        <= '0;
      mode_q      <= M_OFF;
      state       <= UP;
      LED         <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= boundary;
      LED         <= en && ((mode_q == M_ON) || (pwm_cnt < duty));

      if (en) presc_cnt <= (presc_cnt == PLAST) ? '0 : presc_cnt + 1'b1;
      if (stb) pwm_cnt <= pwm_cnt + 1'b1;

      if (boundary) begin
        mode_q <= mode_t'(mode);
        if (mode_t'(mode) != mode_q) begin
          // new mode always starts from a clean slate
          duty    <= '0;
          per_cnt <= '0;
          state   <= UP;
        end else begin
          case (mode_q)
            M_BLINK: begin
              per_cnt <= (per_cnt == BLAST) ? '0 : per_cnt + 1'b1;
              if (per_cnt == BLAST) duty <= (duty == '0) ? DMAX : '0;
            end
            M_BREATHE: begin
              if (per_cnt == SLAST) begin
                per_cnt <= '0;
                if (state == UP) begin
                  duty <= duty + 1'b1;
                  if (duty == DMAX - DONE) state <= DOWN;
                end else begin
                  duty <= duty - 1'b1;
                  if (duty == DONE) state <= UP;
                end
              end else begin
                per_cnt <= per_cnt + 1'b1;
              end
            end
            default: begin
              duty    <= '0;
              per_cnt <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench for led_breathe with PRESC=2, PWM_W=4, STEP_DIV=1:
// 32-cycle PWM period, duty observed at every period_tick.
module tb_led_breathe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       LED;
  logic       period_tick;
  logic [3:0] duty;

  int n_cmp = 0;
  int n_bad = 0;

  led_breathe #(.PRESC(2), .PWM_W(4), .STEP_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .LED(LED), .period_tick(period_tick), .duty(duty)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] mode;  // mode driven just after the previous tick
    int         hi;    // LED-high samples over the following period
    int         duty;  // duty read at the next tick
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Runs to the next period_tick; reports cycles taken and LED-high samples.
  task automatic wait_tick(output int cyc, output int hi);
    cyc = 0;
    hi  = 0;
    do begin
      step();
      cyc++;
      if (LED) hi++;
    end while (!period_tick && cyc < 200);
    if (!period_tick) chk("tick_timeout", 0, 1);
  endtask

  function automatic void add(input logic [1:0] m, input int h, input int d);
    vec_t v;
    v.mode = m; v.hi = h; v.duty = d;
    tbl.push_back(v);
  endfunction

  initial begin
    int cyc, hi, pre, ticks, prev, d;
    int dseq[12] = '{12, 13, 14, 15, 14, 13, 12, 11, 10, 9, 8, 7};

    // off -> on -> breathe; breathe triangle 1..15..0..9
    add(2'b00, 0, 0);
    add(2'b01, 0, 0);
    add(2'b01, 32, 0);
    add(2'b11, 32, 0);
    prev = 0;
    for (int i = 1; i <= 39; i++) begin
      d = (i <= 15) ? i : ((i <= 30) ? 30 - i : i - 30);
      add(2'b11, 2 * prev, d);
      prev = d;
    end

    rst_n = 1'b0; en = 1'b0; mode = 2'b00;
    repeat (3) step();
    chk("reset_LED", int'(LED), 0);
    chk("reset_tick", int'(period_tick), 0);
    chk("reset_duty", int'(duty), 0);

    rst_n = 1'b1; en = 1'b1;
    wait_tick(cyc, hi);
    chk("first_tick_cycles", cyc, 32);
    chk("first_tick_hi", hi, 0);
    chk("first_tick_duty", int'(duty), 0);

    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      wait_tick(cyc, hi);
      chk($sformatf("vec%0d_cycles", i), cyc, 32);
      chk($sformatf("vec%0d_hi", i), hi, tbl[i].hi);
      chk($sformatf("vec%0d_duty", i), int'(duty), tbl[i].duty);
    end

    // pause mid-period at duty 9 (rising)
    pre = 0;
    repeat (5) begin step(); if (LED) pre++; end
    en = 1'b0;
    hi = 0; ticks = 0;
    repeat (100) begin
      step();
      if (LED) hi++;
      if (period_tick) ticks++;
    end
    chk("pause_LED_hi", hi, 0);
    chk("pause_ticks", ticks, 0);
    chk("pause_duty", int'(duty), 9);
    en = 1'b1;
    wait_tick(cyc, hi);
    chk("resume_cycles", cyc, 27);
    chk("resume_hi", hi + pre, 18);
    chk("resume_duty", int'(duty), 10);
    wait_tick(cyc, hi);
    chk("resume2_duty", int'(duty), 11);

    // run down to duty 7 on the falling side
    foreach (dseq[i]) begin
      wait_tick(cyc, hi);
      chk($sformatf("ramp%0d_duty", i), int'(duty), dseq[i]);
    end

    // breathe -> blink: duty clears, first toggle 16 boundaries later
    mode = 2'b10;
    wait_tick(cyc, hi);
    chk("sw_blink_hi", hi, 14);
    chk("sw_blink_duty", int'(duty), 0);
    for (int k = 1; k <= 16; k++) begin
      wait_tick(cyc, hi);
      chk($sformatf("blink_off%0d_hi", k), hi, 0);
      chk($sformatf("blink_off%0d_duty", k), int'(duty), (k == 16) ? 15 : 0);
    end
    for (int k = 1; k <= 16; k++) begin
      wait_tick(cyc, hi);
      chk($sformatf("blink_on%0d_hi", k), hi, 30);
      chk($sformatf("blink_on%0d_duty", k), int'(duty), (k == 16) ? 0 : 15);
    end

    // en drops exactly on the boundary cycle
    ticks = 0;
    repeat (31) begin step(); if (period_tick) ticks++; end
    en = 1'b0;
    repeat (10) begin step(); if (period_tick) ticks++; end
    chk("enb_no_tick", ticks, 0);
    en = 1'b1;
    step();
    chk("enb_tick_on_resume", int'(period_tick), 1);
    wait_tick(cyc, hi);
    chk("enb_next_cycles", cyc, 32);

    // on mode, then asynchronous reset mid-cycle
    mode = 2'b01;
    wait_tick(cyc, hi);
    wait_tick(cyc, hi);
    chk("on_hi", hi, 32);
    step();
    chk("on_LED", int'(LED), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_LED", int'(LED), 0);
    chk("async_rst_duty", int'(duty), 0);
    chk("async_rst_tick", int'(period_tick), 0);
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_breathe.md
# led_breathe

PWM LED driver that sits directly downstream of the 100 MHz board oscillator and drives an on-board LED. It replaces the free-running divider blinker with a controlled output: off, full on, square-wave blink, or "breathing" (triangular duty ramp). All timing comes from a prescaled PWM counter. Duty changes only at PWM period boundaries, so the output never glitches.

## Interface
- PRESC, 390: clk cycles per PWM counter step. 100 MHz / 390 / 256 gives about 1 kHz PWM. Legal range ≥ 1.
- PWM_W, 8: PWM and duty resolution in bits.
- STEP_DIV, 4: PWM periods per duty step in breathe mode. Legal range ≥ 1.
- clk  input  1  100 MHz system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; assertion is asynchronous.
- en  input  1  global enable. Low freezes all counters and forces the outputs low.
- mode  input  2  00 = off, 01 = on, 10 = blink, 11 = breathe.
- LED  output  1  registered PWM output to the LED.
- period_tick  output  1  one-cycle pulse at the end of each PWM period.
- duty  output  PWM_W  duty value currently applied (debug and observation).

## Operation
- Prescaler `presc_cnt`:
  - Counts 0..PRESC-1 while en=1, then wraps to 0.
  - Raises an internal strobe `stb` on the cycle where `presc_cnt`==PRESC-1 and en=1.
- PWM counter `pwm_cnt` (PWM_W bits):
  - Increments on `stb`.
  - Wraps from 2^PWM_W-1 to 0.
  - A "boundary" is `stb` while `pwm_cnt`==2^PWM_W-1.
- At each boundary:
  - period_tick pulses for one cycle (registered).
  - `mode` is sampled into `mode_q`. Mode changes therefore take effect only at boundaries.
  - If the sampled mode differs from `mode_q`: duty←0, `per_cnt`←0, state←UP. The old mode is discarded.
- Duty per `mode_q`:
  - off: duty=0.
  - on: duty=0. LED is forced to 1 independently of the PWM compare.
  - blink:
    - `per_cnt` counts boundaries 0..2^PWM_W-1.
    - On wrap, duty toggles between 0 and 2^PWM_W-1.
    - Result is a square wave with a half-period of 2^PWM_W PWM periods.
  - breathe: FSM with states UP and DOWN.
    - Every STEP_DIV boundaries (`per_cnt` reaching STEP_DIV-1, then cleared), duty moves one step.
    - UP: duty+1. When duty reaches 2^PWM_W-1, state←DOWN on the same step.
    - DOWN: duty-1. When duty reaches 0, state←UP.
    - Duty never overflows or underflows. The extremes are each held for exactly one step.
- LED next value:
  - en=0 → 0.
  - Otherwise, `mode_q`==on → 1.
  - Otherwise → (`pwm_cnt` < duty), an unsigned PWM_W compare.
  - duty=0 means LED is never on. Maximum duty gives (2^PWM_W-1)/2^PWM_W on-time.
- en=0:
  - All counters, duty, state and `mode_q` hold.
  - LED=0 and period_tick=0.
  - Operation resumes from the held values when en returns to 1.

## Timing
- Reset (rst_n=0, asynchronous) sets everything to 0:
  - LED=0, period_tick=0, duty=0.
  - `presc_cnt`, `pwm_cnt` and `per_cnt` =0.
  - state=UP, `mode_q`=off.
- Reset release:
  - The first `stb` occurs PRESC cycles after the first rising edge with en=1.
  - The first boundary occurs PRESC·2^PWM_W cycles after that edge.
- Latency:
  - LED is registered: it reflects `pwm_cnt` and duty one cycle after they change.
  - period_tick is high during the cycle immediately after the boundary edge.
  - A new duty is used starting from the first compare of the new period (`pwm_cnt`=0).
- Mode change in mid-period: no effect until the next boundary. Never more than one partial period of latency.
- Reset asserted mid-operation: outputs go to 0 immediately, with no clock needed.
- en falling at a boundary cycle: that boundary is not processed. It is processed when en returns, with no lost or double tick.

## Test plan
Bench parameters: PRESC=2, PWM_W=4, STEP_DIV=1 unless stated.
1. Reset, then en=1, mode=00 → LED=0 for all cycles. period_tick pulses every 32 cycles. duty=0.
2. mode=01 applied mid-period → LED stays 0 until the first boundary, then is 1 continuously. Asserting rst_n=0 asynchronously drops LED to 0 within the same cycle.
3. mode=11 → duty reads 1, 2, …, 15, 14, …, 0, 1 on successive boundaries. For duty=5 at steady state, LED is high exactly 10 of every 32 cycles.
4. mode=10 → duty alternates 0 and 15 every 16 boundaries (512 cycles). LED is high 30 of 32 cycles in the "on" half and 0 in the "off" half.
5. Breathe running at duty=9, then en=0 for 100 cycles, then en=1 → LED=0 and period_tick=0 during the pause. After the pause, `pwm_cnt`, duty and direction continue unchanged.
6. Switch mode 11→10 while duty=7 (DOWN) → at the next boundary duty=0 and blink starts with `per_cnt`=0. The first toggle to 15 occurs 16 boundaries later.
